// File: rtl/telemetry_uart_tx.sv
// ----------------------------------------------------------------------------
// telemetry_uart_tx
//
// Sends one 11-byte telemetry frame over an 8N1 UART line when asked. The
// frame is:
//   A5, roll hi/lo, pitch hi/lo, yaw hi/lo, motor hi/lo, status, checksum
// Each 10-bit signed field goes out as a sign-extended high byte
// {sign x6, v[9:8]} followed by the low byte v[7:0]. The checksum is the XOR
// of the ten bytes before it. Bytes are sent back-to-back with no idle gap.
//
// Parameters
//   CLK_HZ      input clock frequency in Hz
//   BAUD        serial bit rate; DIVISOR = CLK_HZ / BAUD clocks per bit (>= 2)
//
// Ports
//   clock       sole clock, rising edge
//   reset       asynchronous active-high reset
//   send        request one frame; only honoured while busy is low
//   mpu_roll    signed 10-bit roll
//   mpu_pitch   signed 10-bit pitch
//   mpu_yaw     signed 10-bit yaw
//   motor_speed signed 10-bit motor speed
//   status      8-bit status flags, sent verbatim
//   tx          UART serial out (idles high)
//   busy        high while a frame is in flight
//   done        one-cycle pulse when the final stop bit has completed
// ----------------------------------------------------------------------------
module telemetry_uart_tx #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [9:0] mpu_roll,
    input  logic [9:0] mpu_pitch,
    input  logic [9:0] mpu_yaw,
    input  logic [9:0] motor_speed,
    input  logic [7:0] status,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DIVISOR = CLK_HZ / BAUD;
    localparam int unsigned CntW    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIVISOR - 1);

    localparam logic [7:0] SyncByte = 8'hA5;
    localparam logic [3:0] LastByte = 4'd10;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [3:0]      byte_idx_q, byte_idx_d;
    logic            done_q, done_d;

    // Field snapshot taken on the accepting edge.
    logic [9:0] roll_q, pitch_q, yaw_q, motor_q;
    logic [7:0] status_q;

    logic       accept;
    logic       bit_end;
    logic [7:0] frame_byte;
    logic [7:0] checksum;

    function automatic logic [7:0] hi_byte(input logic [9:0] v);
        return {{6{v[9]}}, v[9:8]};
    endfunction

    assign accept  = (state_q == StIdle) && send;
    assign bit_end = (cnt_q == CntMax);

    // ------------------------------------------------------------------
    // Field capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            roll_q   <= '0;
            pitch_q  <= '0;
            yaw_q    <= '0;
            motor_q  <= '0;
            status_q <= '0;
        end else if (accept) begin
            roll_q   <= mpu_roll;
            pitch_q  <= mpu_pitch;
            yaw_q    <= mpu_yaw;
            motor_q  <= motor_speed;
            status_q <= status;
        end
    end

    // ------------------------------------------------------------------
    // Frame byte selection and checksum
    // ------------------------------------------------------------------
    assign checksum = SyncByte
                    ^ hi_byte(roll_q)  ^ roll_q[7:0]
                    ^ hi_byte(pitch_q) ^ pitch_q[7:0]
                    ^ hi_byte(yaw_q)   ^ yaw_q[7:0]
                    ^ hi_byte(motor_q) ^ motor_q[7:0]
                    ^ status_q;

    always_comb begin
        frame_byte = checksum;
        case (byte_idx_q)
            4'd0:    frame_byte = SyncByte;
            4'd1:    frame_byte = hi_byte(roll_q);
            4'd2:    frame_byte = roll_q[7:0];
            4'd3:    frame_byte = hi_byte(pitch_q);
            4'd4:    frame_byte = pitch_q[7:0];
            4'd5:    frame_byte = hi_byte(yaw_q);
            4'd6:    frame_byte = yaw_q[7:0];
            4'd7:    frame_byte = hi_byte(motor_q);
            4'd8:    frame_byte = motor_q[7:0];
            4'd9:    frame_byte = status_q;
            default: frame_byte = checksum;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit/byte sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (send) begin
                    state_d    = StStart;
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = StStop;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (byte_idx_q == LastByte) begin
                        // Registered done lands on the same cycle busy drops.
                        state_d    = StIdle;
                        byte_idx_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = StStart;
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = StIdle;
                cnt_d      = '0;
                bit_idx_d  = '0;
                byte_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded straight from state so reset forces tx high at once.
    // ------------------------------------------------------------------
    always_comb begin
        tx = 1'b1;
        case (state_q)
            StStart: tx = 1'b0;
            StData:  tx = frame_byte[bit_idx_q];
            default: tx = 1'b1;
        endcase
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_telemetry_uart_tx.sv
module tb_telemetry_uart_tx;

    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic       send;
    logic [9:0] mpu_roll, mpu_pitch, mpu_yaw, motor_speed;
    logic [7:0] status;
    logic       tx, busy, done;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb_q[$];
    logic [7:0] rx_log[$];
    int         done_cnt = 0;

    telemetry_uart_tx #(
        .CLK_HZ(4),
        .BAUD  (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .send       (send),
        .mpu_roll   (mpu_roll),
        .mpu_pitch  (mpu_pitch),
        .mpu_yaw    (mpu_yaw),
        .motor_speed(motor_speed),
        .status     (status),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hi_of(input logic [9:0] v);
        return {{6{v[9]}}, v[9:8]};
    endfunction

    // Reference frame model feeding the scoreboard.
    task automatic push_frame(input logic [9:0] r, input logic [9:0] p, input logic [9:0] y,
                              input logic [9:0] m, input logic [7:0] s);
        logic [7:0] b[11];
        logic [7:0] c;
        b[0] = 8'hA5;
        b[1] = hi_of(r); b[2] = r[7:0];
        b[3] = hi_of(p); b[4] = p[7:0];
        b[5] = hi_of(y); b[6] = y[7:0];
        b[7] = hi_of(m); b[8] = m[7:0];
        b[9] = s;
        c = 8'h00;
        for (int i = 0; i < 10; i++) c = c ^ b[i];
        b[10] = c;
        for (int i = 0; i < 11; i++) sb_q.push_back(b[i]);
    endtask

    task automatic set_fields(input logic [9:0] r, input logic [9:0] p, input logic [9:0] y,
                              input logic [9:0] m, input logic [7:0] s);
        mpu_roll = r; mpu_pitch = p; mpu_yaw = y; motor_speed = m; status = s;
    endtask

    // Called at a negedge; returns at the first busy negedge.
    task automatic pulse_send();
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(negedge clock);
            n++;
        end
    endtask

    // UART receiver: samples the middle of each bit, checks framing, scores bytes.
    bit         mon_on = 1'b0;
    int         mon_cnt;
    int         mon_k;
    logic [9:0] mon_bits;
    logic [7:0] mon_byte;
    logic [7:0] mon_exp;

    always @(negedge clock) begin
        if (done) done_cnt++;
        if (reset) begin
            mon_on = 1'b0;
        end else if (!mon_on) begin
            if (tx == 1'b0) begin
                mon_on  = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % D == D / 2) begin
                mon_k = mon_cnt / D;
                mon_bits[mon_k] = tx;
                if (mon_k == 9) begin
                    mon_on   = 1'b0;
                    mon_byte = mon_bits[8:1];
                    check_eq("rx_start_bit", 32'(mon_bits[0]), 32'd0);
                    check_eq("rx_stop_bit", 32'(mon_bits[9]), 32'd1);
                    rx_log.push_back(mon_byte);
                    if (sb_q.size() == 0) begin
                        check_eq("rx_unexpected_byte", 32'(sb_q.size()), 32'd1);
                    end else begin
                        mon_exp = sb_q.pop_front();
                        check_eq("rx_byte", 32'(mon_byte), 32'(mon_exp));
                    end
                end
            end
        end
    end

    logic [7:0] basic_exp[11] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h05, 8'hFF,
                                  8'hFF, 8'h01, 8'h90, 8'h00, 8'h31};
    logic [9:0] wave;
    logic [7:0] xs;
    int         n, n1, n2, base;

    initial begin
        reset = 1'b1;
        send  = 1'b0;
        set_fields(10'h000, 10'h000, 10'h000, 10'h000, 8'h00);
        repeat (2) @(negedge clock);
        check_eq("reset_tx", 32'(tx), 32'd1);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("idle_tx", 32'(tx), 32'd1);

        // Basic frame with exact bit timing of byte 0.
        rx_log.delete();
        for (int i = 0; i < 11; i++) sb_q.push_back(basic_exp[i]);
        set_fields(10'd0, 10'd5, 10'h3FF, 10'd400, 8'h00);
        pulse_send();
        check_eq("basic_busy_rise", 32'(busy), 32'd1);
        wave = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10 * D; i++) begin
            check_eq("byte0_wave", 32'(tx), 32'(wave[i / D]));
            @(negedge clock);
        end
        check_eq("byte1_start_no_gap", 32'(tx), 32'd0);
        wait_done(600, n);
        check_eq("basic_done_latency", 32'(n + 10 * D), 32'd440);
        check_eq("basic_busy_at_done", 32'(busy), 32'd0);
        @(negedge clock);
        check_eq("basic_done_one_cycle", 32'(done), 32'd0);
        check_eq("basic_sb_empty", 32'(sb_q.size()), 32'd0);
        check_eq("basic_rx_count", 32'(rx_log.size()), 32'd11);

        // Send while busy, with changed inputs, is ignored.
        rx_log.delete();
        base = done_cnt;
        push_frame(10'd100, 10'h3FD, 10'd511, 10'h338, 8'h5A);
        set_fields(10'd100, 10'h3FD, 10'd511, 10'h338, 8'h5A);
        pulse_send();
        repeat (99) @(negedge clock);
        set_fields(10'h155, 10'h0AA, 10'h001, 10'h200, 8'hC3);
        pulse_send();
        wait_done(600, n);
        check_eq("reject_done_latency", 32'(n + 100), 32'd440);
        repeat (60) @(negedge clock);
        check_eq("reject_one_done", 32'(done_cnt - base), 32'd1);
        check_eq("reject_idle_after", 32'(busy), 32'd0);
        check_eq("reject_sb_empty", 32'(sb_q.size()), 32'd0);
        check_eq("reject_rx_count", 32'(rx_log.size()), 32'd11);

        // Negative extension of -512.
        rx_log.delete();
        push_frame(10'd7, 10'h200, 10'd0, 10'd1, 8'h81);
        set_fields(10'd7, 10'h200, 10'd0, 10'd1, 8'h81);
        pulse_send();
        wait_done(600, n);
        check_eq("negext_done_latency", 32'(n), 32'd440);
        repeat (2) @(negedge clock);
        check_eq("negext_rx_count", 32'(rx_log.size()), 32'd11);
        if (rx_log.size() == 11) begin
            check_eq("negext_b3", 32'(rx_log[3]), 32'hFE);
            check_eq("negext_b4", 32'(rx_log[4]), 32'h00);
            xs = 8'h00;
            for (int i = 0; i < 10; i++) xs = xs ^ rx_log[i];
            check_eq("negext_checksum", 32'(rx_log[10]), 32'(xs));
        end

        // Back-to-back with send held high.
        rx_log.delete();
        base = done_cnt;
        push_frame(10'h2AB, 10'd33, 10'h3C0, 10'd256, 8'h0F);
        push_frame(10'h2AB, 10'd33, 10'h3C0, 10'd256, 8'h0F);
        set_fields(10'h2AB, 10'd33, 10'h3C0, 10'd256, 8'h0F);
        send = 1'b1;
        @(negedge clock);
        check_eq("b2b_busy_rise", 32'(busy), 32'd1);
        wait_done(600, n1);
        check_eq("b2b_first_done", 32'(n1), 32'd440);
        @(negedge clock);
        check_eq("b2b_restart_tx", 32'(tx), 32'd0);
        check_eq("b2b_restart_busy", 32'(busy), 32'd1);
        wait_done(600, n2);
        send = 1'b0;
        check_eq("b2b_second_done", 32'(n1 + 1 + n2), 32'd881);
        repeat (10) @(negedge clock);
        check_eq("b2b_done_count", 32'(done_cnt - base), 32'd2);
        check_eq("b2b_sb_empty", 32'(sb_q.size()), 32'd0);
        check_eq("b2b_rx_count", 32'(rx_log.size()), 32'd22);

        // Mid-frame reset aborts cleanly; next frame is intact.
        base = done_cnt;
        push_frame(10'd1, 10'd2, 10'd3, 10'd4, 8'h55);
        set_fields(10'd1, 10'd2, 10'd3, 10'd4, 8'h55);
        pulse_send();
        repeat (199) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check_eq("midrst_tx", 32'(tx), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        sb_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (300) @(negedge clock);
        check_eq("midrst_no_done", 32'(done_cnt - base), 32'd0);
        check_eq("midrst_idle_tx", 32'(tx), 32'd1);
        rx_log.delete();
        push_frame(10'h3FE, 10'd511, 10'h201, 10'd99, 8'hE7);
        set_fields(10'h3FE, 10'd511, 10'h201, 10'd99, 8'hE7);
        pulse_send();
        wait_done(600, n);
        check_eq("postrst_done_latency", 32'(n), 32'd440);
        repeat (2) @(negedge clock);
        check_eq("postrst_sb_empty", 32'(sb_q.size()), 32'd0);
        check_eq("postrst_rx_count", 32'(rx_log.size()), 32'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/telemetry_uart_tx.md
TELEMETRY_UART_TX -- requirements
Module: telemetry_uart_tx

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide CLK_HZ, 100_000_000, input clock frequency in Hz.
REQ-002 SHALL provide BAUD, 115_200, serial bit rate.
REQ-003 SHALL derive DIVISOR = CLK_HZ/BAUD (integer division), clocks per bit; DIVISOR >= 2.
Ports (name, direction, width, meaning):
REQ-004 SHALL provide: clock, input, 1, sole clock, rising edge.
REQ-005 SHALL provide: reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL provide: send, input, 1, request to transmit one telemetry frame.
REQ-007 SHALL provide: mpu_roll, mpu_pitch, mpu_yaw, input, 10 each, signed attitude values.
REQ-008 SHALL provide: motor_speed, input, 10, signed motor speed.
REQ-009 SHALL provide: status, input, 8, status flags, sent verbatim.
REQ-010 SHALL provide: tx, output, 1, UART serial out; drives the BLE module RX pin.
REQ-011 SHALL provide: busy, output, 1, high while a frame is in flight.
REQ-012 SHALL provide: done, output, 1, one-cycle pulse at frame completion.

Function
REQ-013 SHALL accept send only when busy==0; send while busy==1 SHALL be ignored, with no queueing.
REQ-014 SHALL latch all field inputs on the accepting edge; input changes after acceptance SHALL NOT affect the frame in flight.
REQ-015 SHALL assert busy on the cycle after acceptance; the start bit of byte 0 SHALL begin on that same cycle.
REQ-016 SHALL send an 11-byte frame in this order: B0=0xA5; B1,B2=roll; B3,B4=pitch; B5,B6=yaw; B7,B8=motor_speed; B9=status; B10=checksum.
REQ-017 SHALL send each 10-bit field as a high byte {sign bit x6, v[9:8]} followed by a low byte v[7:0].
REQ-018 SHALL compute checksum as the XOR of B0 through B9.
REQ-019 SHALL send each byte as 8N1: start bit 0, then 8 data bits LSB first, then stop bit 1; each bit SHALL hold exactly DIVISOR cycles.
REQ-020 SHALL send bytes back-to-back: the next start bit SHALL immediately follow the previous stop bit, with no idle gap.
REQ-021 SHALL implement states IDLE, START, DATA, STOP. Transitions:
- IDLE->START on accept.
- START->DATA after DIVISOR cycles.
- DATA->STOP after 8 bits.
- STOP->START when byte index < 10.
- STOP->IDLE when byte index == 10.
REQ-022 SHALL hold tx=1 in IDLE.
REQ-023 SHALL make total frame duration from first start bit to end of last stop bit exactly 110*DIVISOR cycles.
REQ-024 SHALL, on the cycle the final stop bit completes, assert done for one cycle and deassert busy on that same cycle.
REQ-025 SHALL accept a send asserted during the done cycle, starting a new frame on the next cycle.
REQ-026 SHALL keep the bit counter (0..DIVISOR-1), bit index (0..7) and byte index (0..10) wrap-free; each counter SHALL reset to 0 at every state boundary.

Reset
REQ-027 SHALL, while reset is high, force tx=1, busy=0, done=0, state=IDLE and all counters to 0, asynchronously.
REQ-028 SHALL, on reset mid-frame, abort the frame immediately, drive tx high within the same cycle, and not assert done.
REQ-029 SHALL, after reset release, ignore send on the release cycle only if it coincides with reset; acceptance resumes on the first clock edge with reset low.

Verification (DIVISOR=4 via CLK_HZ=4, BAUD=1)
REQ-030 SHALL cover basic frame: roll=0, pitch=5, yaw=-1, motor_speed=400, status=0x00, one send pulse -> bytes A5 00 00 00 05 FF FF 01 90 00 31; done exactly 440 cycles after busy rises.
REQ-031 SHALL cover bit timing: check the first byte 0xA5 at DIVISOR=4 -> tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; next start bit immediately follows.
REQ-032 SHALL cover busy rejection: send re-pulsed at cycle 100 of a frame with changed inputs -> frame unchanged, exactly one done.
REQ-033 SHALL cover back-to-back: send held high continuously -> second frame starts the cycle after done; 2 done pulses in 881 cycles; no idle bit between frames.
REQ-034 SHALL cover mid-frame reset: reset pulsed at cycle 200 -> tx=1 and busy=0 the same cycle, no done; a later send produces a complete, correct frame.
REQ-035 SHALL cover negative extension: pitch=-512 (0x200) -> B3=0xFE, B4=0x00; checksum matches the XOR of B0..B9.
